// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
// Holds the FSM state encoding, the requester count, the index width and the
// default grant-hold limit used when RR_ARB_TIMEOUT_EN is defined.
package rr_arbiter_8_pkg;

  localparam int N_REQ           = 8;
  localparam int IDX_W           = 3;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter_8_pick.sv
// Round-robin winner selection (purely combinational).
// Searches req starting one past last_idx and wrapping modulo N_REQ, so the
// most recently served requester has the lowest priority.
module rr_pick
  import rr_arbiter_8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  logic found;

  // Scan last_idx+1 .. last_idx+8; the 3-bit add wraps 7 -> 0 on its own.
  always_comb begin
    any    = |req;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [IDX_W-1:0] cand;
      cand = last_idx + IDX_W'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter for one shared 8-way select resource.
// Grants one requester at a time, holds the grant until released, and inserts
// one IDLE bubble between consecutive grants. The winner is presented as a
// registered 3-bit index plus a one-hot enable gated by gnt_valid.
// Optional feature: define RR_ARB_TIMEOUT_EN to force a revoke after
// TIMEOUT_CYC grant cycles without release (timeout pulses for one cycle).
// "release" is a reserved word in SystemVerilog, so the port is release_i.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             release_i,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic             busy,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic             timeout_q, timeout_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_winner;
  logic             expired;

  rr_pick u_pick (
    .req      (req),
    .last_idx (last_idx_q),
    .any      (pick_any),
    .winner   (pick_winner)
  );

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds (grant cycle number - 1); the last allowed cycle is TIMEOUT_CYC-1.
  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Grant-age counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  // No counter in this build: a grant never expires. The parameter is still
  // referenced so both builds share the same interface without unused warnings.
  assign expired = 1'b0 & (TIMEOUT_CYC > 0);
`endif

  // FSM, grant index, round-robin pointer and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      last_idx_q <= IDX_W'(N_REQ - 1);
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic: IDLE picks a winner, GRANT waits for release or expiry.
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    timeout_d  = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d   = ST_GRANT;
          gnt_idx_d = pick_winner;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (release_i || expired) begin
          state_d    = ST_IDLE;
          last_idx_d = gnt_idx_q;
          // A release on the expiry edge wins: it is a normal release.
          timeout_d  = expired && !release_i;
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt_valid  = (state_q == ST_GRANT);
  assign busy       = (state_q == ST_GRANT);
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_valid ? (N_REQ'(1) << gnt_idx_q) : '0;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus random traffic,
// scored against a behavioural round-robin model through an expectation queue.
module tb_rr_arbiter_8;

  localparam int TOUT = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       release_i;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.TIMEOUT_CYC(TOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .release_i  (release_i),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .busy       (busy),
    .timeout    (timeout)
  );

  typedef struct packed {
    bit       valid;
    bit [2:0] idx;
    bit [7:0] oh;
    bit       busy;
    bit       tout;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Behavioural model: who holds the resource, who was served last, and how
  // many cycles the current holder has had it.
  bit m_grant;
  int m_idx;
  int m_last;
  int m_cnt;
  bit m_tout;

  function automatic void model_reset();
    m_grant = 1'b0;
    m_idx   = 0;
    m_last  = 7;
    m_cnt   = 0;
    m_tout  = 1'b0;
  endfunction

  function automatic void model_step(input bit [7:0] r, input bit rel);
    if (!m_grant) begin
      m_tout = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        int j;
        j = (m_last + k) % 8;
        if (r[j]) begin
          m_grant = 1'b1;
          m_idx   = j;
          m_cnt   = 1;
          break;
        end
      end
    end else if (rel) begin
      m_grant = 1'b0;
      m_last  = m_idx;
      m_tout  = 1'b0;
    end else if (TO_ON && m_cnt == TOUT) begin
      m_grant = 1'b0;
      m_last  = m_idx;
      m_tout  = 1'b1;
    end else begin
      m_cnt  = m_cnt + 1;
      m_tout = 1'b0;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.valid = m_grant;
    e.idx   = 3'(m_idx);
    e.oh    = m_grant ? (8'd1 << m_idx) : 8'd0;
    e.busy  = m_grant;
    e.tout  = m_tout;
    return e;
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h (v,idx,oh,busy,to) expected %h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of stimulus; the model predicts the state after the edge.
  task automatic step(input bit [7:0] r, input bit rel);
    exp_t e;
    req       = r;
    release_i = rel;
    model_step(r, rel);
    e = model_out();
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  function automatic logic [13:0] dut_vec();
    return {gnt_valid, gnt_idx, gnt_onehot, busy, timeout};
  endfunction

  function automatic logic [13:0] pack_grant(input int idx);
    return {1'b1, 3'(idx), 8'(8'd1 << idx), 1'b1, 1'b0};
  endfunction

  // Monitor: every cycle the DUT presents a state; compare it to the queue head.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("cycle", dut_vec(), e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req       = 8'hFF;
    release_i = 1'b0;
    model_reset();
    #12;
    check("reset_outputs", dut_vec(), 14'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Rotation from the reset pointer: 0,1,...,7,0.
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0);
      check("rotation_idx", dut_vec(), pack_grant(i % 8));
      step(8'hFF, 1'b1);
    end

    // Single requester 5 with release, bubble, then re-grant.
    step(8'h20, 1'b0);
    check("single_grant", dut_vec(), pack_grant(5));
    step(8'h20, 1'b1);
    check("single_bubble", dut_vec(), {1'b0, 3'd5, 8'h00, 1'b0, 1'b0});
    step(8'h20, 1'b0);
    check("single_regrant", dut_vec(), pack_grant(5));
    step(8'h00, 1'b1);

    // Wrap/skip with last served = 6 and req = 0x05.
    step(8'h40, 1'b0);
    step(8'h40, 1'b1);
    step(8'h05, 1'b0);
    check("wrap_first", dut_vec(), pack_grant(0));
    step(8'h05, 1'b1);
    step(8'h05, 1'b0);
    check("wrap_second", dut_vec(), pack_grant(2));
    step(8'h05, 1'b1);
    step(8'h05, 1'b0);
    check("wrap_third", dut_vec(), pack_grant(0));
    step(8'h00, 1'b1);

    // Release while idle has no effect; then grant 3 and drop its request.
    step(8'h00, 1'b1);
    step(8'h08, 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 1; i < TOUT; i++) step(8'h00, 1'b0);
    check("timeout_last_cycle", dut_vec(), pack_grant(3));
    step(8'h00, 1'b0);
    check("timeout_revoke", dut_vec(), {1'b0, 3'd3, 8'h00, 1'b0, 1'b1});
    step(8'h00, 1'b0);
    check("timeout_pulse_end", dut_vec(), {1'b0, 3'd3, 8'h00, 1'b0, 1'b0});
`else
    for (int i = 0; i < 10; i++) step(8'h00, 1'b0);
    check("hold_after_drop", dut_vec(), pack_grant(3));
    step(8'h00, 1'b1);
    step(8'h10, 1'b0);
    for (int i = 0; i < 110; i++) step(8'h00, 1'b0);
    check("hold_long", dut_vec(), pack_grant(4));
`endif
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    // Asynchronous reset in the middle of a grant.
    step(8'h80, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_grant", dut_vec(), 14'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(8'hFF, 1'b0);
    check("pointer_after_reset", dut_vec(), pack_grant(0));
    step(8'hFF, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      bit [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      step(r, ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
